// File: rtl/sfifo_pkg.sv
// Shared helpers for the synchronous FIFO: width calculations and the
// power-of-two depth check used at elaboration time.
package sfifo_pkg;

    // Address bits needed to index a RAM of the given depth (at least one bit).
    function automatic int addr_width(input int depth);
        return (depth > 32'sd1) ? $clog2(depth) : 32'sd1;
    endfunction

    // Level bits: RAM words plus the one-word output stage, plus headroom for DEPTH+1.
    function automatic int level_width(input int depth);
        return $clog2(depth + 32'sd2);
    endfunction

    // True when depth is a power of two and at least two words.
    function automatic bit is_pow2(input int depth);
        return (depth >= 32'sd2) && ((depth & (depth - 32'sd1)) == 32'sd0);
    endfunction

endpackage

// File: rtl/sfifo_ptr.sv
// AW-bit RAM pointer with increment enable; wraps naturally at 2^AW.
module sfifo_ptr #(
    parameter int AW = 9
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc,
    output logic [AW-1:0] ptr
);

    logic [AW-1:0] ptr_d;
    logic [AW-1:0] ptr_q;

    // Next pointer value: advance by one when enabled, otherwise hold.
    always_comb begin
        if (inc) begin
            ptr_d = ptr_q + AW'(1);
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Pointer register, cleared by the asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/sfifo_rd_wr_ctrl.sv
// Read/write controller turning an external synchronous dual-port RAM into a
// valid/ready FIFO. The RAM's registered read data is the output stage; this
// block holds only pointers, the RAM occupancy count and the output-valid flag.
// Optional macro SFIFO_CTRL_WATERMARK_EN adds almost_full/almost_empty outputs.
module sfifo_rd_wr_ctrl
    import sfifo_pkg::*;
#(
    parameter int DEPTH = 512,
    parameter int WIDTH = 8,
`ifdef SFIFO_CTRL_WATERMARK_EN
    parameter int AFULL_THR  = DEPTH - 2,
    parameter int AEMPTY_THR = 2,
`endif
    localparam int AW = addr_width(DEPTH),
    localparam int CW = level_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             ram_wr_en,
    output logic [AW-1:0]    ram_wr_addr,
    output logic [WIDTH-1:0] ram_wr_data,
    output logic             ram_rd_en,
    output logic [AW-1:0]    ram_rd_addr,
`ifdef SFIFO_CTRL_WATERMARK_EN
    output logic             almost_full,
    output logic             almost_empty,
`endif
    output logic [CW-1:0]    level
);

    if (!is_pow2(DEPTH)) begin : g_depth_chk
        $error("sfifo_rd_wr_ctrl: DEPTH must be a power of two and at least 2");
    end

    logic          wr_fire_s;
    logic          rd_en_s;
    logic [CW-1:0] ram_cnt_d;
    logic [CW-1:0] ram_cnt_q;
    logic          out_valid_d;
    logic          out_valid_q;
    logic [CW-1:0] level_d;
    logic [CW-1:0] level_q;
    logic          in_ready_d;
    logic          in_ready_q;
`ifdef SFIFO_CTRL_WATERMARK_EN
    logic          almost_full_d;
    logic          almost_full_q;
    logic          almost_empty_d;
    logic          almost_empty_q;
`endif

    // Handshake decode and next-state for count, output stage, level and ready.
    // Full/empty come only from ram_cnt; a write to a full RAM is refused even
    // when a read issues in the same cycle, and a word written on an edge is not
    // readable until the following cycle because ram_cnt counts committed writes.
    always_comb begin
        wr_fire_s = in_valid & in_ready_q;
        rd_en_s   = (ram_cnt_q != CW'(0)) & (~out_valid_q | out_ready);

        ram_cnt_d = ram_cnt_q + CW'(wr_fire_s) - CW'(rd_en_s);

        if (rd_en_s) begin
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end

        level_d    = ram_cnt_d + CW'(out_valid_d);
        in_ready_d = (ram_cnt_d != CW'(DEPTH));
    end

`ifdef SFIFO_CTRL_WATERMARK_EN
    // Watermark flags evaluated on the next-cycle level so they register in step with level.
    always_comb begin
        almost_full_d  = (level_d >= CW'(AFULL_THR));
        almost_empty_d = (level_d <= CW'(AEMPTY_THR));
    end

    // Watermark flag registers; an empty FIFO is almost-empty, never almost-full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            almost_full_q  <= 1'b0;
            almost_empty_q <= 1'b1;
        end else begin
            almost_full_q  <= almost_full_d;
            almost_empty_q <= almost_empty_d;
        end
    end

    assign almost_full  = almost_full_q;
    assign almost_empty = almost_empty_q;
`endif

    // Occupancy, output-stage valid, level and ready registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            level_q     <= '0;
            in_ready_q  <= 1'b1;
        end else begin
            ram_cnt_q   <= ram_cnt_d;
            out_valid_q <= out_valid_d;
            level_q     <= level_d;
            in_ready_q  <= in_ready_d;
        end
    end

    sfifo_ptr #(
        .AW(AW)
    ) u_wr_ptr (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (wr_fire_s),
        .ptr  (ram_wr_addr)
    );

    sfifo_ptr #(
        .AW(AW)
    ) u_rd_ptr (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (rd_en_s),
        .ptr  (ram_rd_addr)
    );

    assign ram_wr_en   = wr_fire_s;
    assign ram_wr_data = in_data;
    assign ram_rd_en   = rd_en_s;
    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign level       = level_q;

endmodule

// File: tb/tb_sfifo_rd_wr_ctrl.sv
// Bench for sfifo_rd_wr_ctrl with DEPTH=4, WIDTH=8 and a behavioural RAM.
// Reference model: a queue of accepted words, each stamped with its accept edge;
// a word becomes visible at the output two cycles after it is accepted once it
// reaches the head of the queue.
module tb_sfifo_rd_wr_ctrl;

    localparam int DEPTH = 4;
    localparam int WIDTH = 8;
    localparam int AW    = 2;
    localparam int CW    = 3;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic             ram_wr_en;
    logic [AW-1:0]    ram_wr_addr;
    logic [WIDTH-1:0] ram_wr_data;
    logic             ram_rd_en;
    logic [AW-1:0]    ram_rd_addr;
    logic [CW-1:0]    level;
`ifdef SFIFO_CTRL_WATERMARK_EN
    logic             almost_full;
    logic             almost_empty;
`endif

    sfifo_rd_wr_ctrl #(
        .DEPTH(DEPTH),
`ifdef SFIFO_CTRL_WATERMARK_EN
        .AFULL_THR(3),
        .AEMPTY_THR(2),
`endif
        .WIDTH(WIDTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ram_wr_en  (ram_wr_en),
        .ram_wr_addr(ram_wr_addr),
        .ram_wr_data(ram_wr_data),
        .ram_rd_en  (ram_rd_en),
        .ram_rd_addr(ram_rd_addr),
`ifdef SFIFO_CTRL_WATERMARK_EN
        .almost_full (almost_full),
        .almost_empty(almost_empty),
`endif
        .level      (level)
    );

    // Synchronous dual-port RAM with registered read data.
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_data;
    always @(posedge clk) begin
        if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
        if (ram_rd_en) rd_data <= mem[ram_rd_addr];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [7:0] data;
        int         t;
    } ent_t;
    ent_t q[$];
    int   edge_cnt = 0;
    int   wr_cnt   = 0;

    typedef struct {
        logic       iv;
        logic [7:0] d;
        logic       ordy;
        int         lvl;
        int         ir;
        int         ov;
        int         rd;
        logic [7:0] data;
    } vec_t;
    vec_t tbl[18];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    // One cycle: drive inputs just after a falling edge, compare against the model,
    // then advance the model across the rising edge.
    task automatic step(input logic iv, input logic [7:0] d, input logic ordy);
        int exp_lvl;
        int exp_ov;
        int exp_ir;
        bit wr;
        bit rd;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        #2;
        exp_lvl = q.size();
        exp_ov  = (q.size() > 0 && q[0].t <= edge_cnt - 1) ? 1 : 0;
        exp_ir  = ((exp_lvl - exp_ov) < DEPTH) ? 1 : 0;
        chk("level", int'(level), exp_lvl);
        chk("out_valid", int'(out_valid), exp_ov);
        chk("in_ready", int'(in_ready), exp_ir);
        wr = iv && (exp_ir != 0);
        rd = (exp_ov != 0) && ordy;
        chk("ram_wr_en", int'(ram_wr_en), int'(wr));
        if (wr) begin
            chk("ram_wr_addr", int'(ram_wr_addr), wr_cnt % DEPTH);
            chk("ram_wr_data", int'(ram_wr_data), int'(d));
        end
        if (exp_ov != 0) chk("head_data", int'(rd_data), int'(q[0].data));
`ifdef SFIFO_CTRL_WATERMARK_EN
        chk("almost_full", int'(almost_full), (exp_lvl >= 3) ? 1 : 0);
        chk("almost_empty", int'(almost_empty), (exp_lvl <= 2) ? 1 : 0);
`endif
        @(posedge clk);
        if (rd) void'(q.pop_front());
        if (wr) begin
            q.push_back('{d, edge_cnt + 1});
            wr_cnt++;
        end
        edge_cnt++;
        @(negedge clk);
    endtask

    task automatic model_reset();
        q.delete();
        wr_cnt = 0;
    endtask

    initial begin
        // Directed vectors: single word with held output, then fill/full/drain.
        tbl[0]  = '{1'b1, 8'hA1, 1'b0, 0, 1, 0, 0, 8'h00};
        tbl[1]  = '{1'b0, 8'h00, 1'b0, 1, 1, 0, 1, 8'h00};
        tbl[2]  = '{1'b0, 8'h00, 1'b0, 1, 1, 1, 0, 8'hA1};
        tbl[3]  = '{1'b0, 8'h00, 1'b0, 1, 1, 1, 0, 8'hA1};
        tbl[4]  = '{1'b0, 8'h00, 1'b1, 1, 1, 1, 0, 8'hA1};
        tbl[5]  = '{1'b0, 8'h00, 1'b0, 0, 1, 0, 0, 8'h00};
        tbl[6]  = '{1'b1, 8'h10, 1'b0, 0, 1, 0, 0, 8'h00};
        tbl[7]  = '{1'b1, 8'h11, 1'b0, 1, 1, 0, 1, 8'h00};
        tbl[8]  = '{1'b1, 8'h12, 1'b0, 2, 1, 1, 0, 8'h10};
        tbl[9]  = '{1'b1, 8'h13, 1'b0, 3, 1, 1, 0, 8'h10};
        tbl[10] = '{1'b1, 8'h14, 1'b0, 4, 1, 1, 0, 8'h10};
        tbl[11] = '{1'b1, 8'h15, 1'b0, 5, 0, 1, 0, 8'h10};
        tbl[12] = '{1'b1, 8'h15, 1'b1, 5, 0, 1, 1, 8'h10};
        tbl[13] = '{1'b0, 8'h00, 1'b1, 4, 1, 1, 1, 8'h11};
        tbl[14] = '{1'b0, 8'h00, 1'b1, 3, 1, 1, 1, 8'h12};
        tbl[15] = '{1'b0, 8'h00, 1'b1, 2, 1, 1, 1, 8'h13};
        tbl[16] = '{1'b0, 8'h00, 1'b1, 1, 1, 1, 0, 8'h14};
        tbl[17] = '{1'b0, 8'h00, 1'b1, 0, 1, 0, 0, 8'h00};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        chk("rst_level", int'(level), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_wr_en", int'(ram_wr_en), 0);
        chk("rst_rd_en", int'(ram_rd_en), 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);

        for (int i = 0; i < 18; i++) begin
            in_valid  = tbl[i].iv;
            in_data   = tbl[i].d;
            out_ready = tbl[i].ordy;
            #1;
            chk($sformatf("tbl%0d_level", i), int'(level), tbl[i].lvl);
            chk($sformatf("tbl%0d_in_ready", i), int'(in_ready), tbl[i].ir);
            chk($sformatf("tbl%0d_out_valid", i), int'(out_valid), tbl[i].ov);
            chk($sformatf("tbl%0d_rd_en", i), int'(ram_rd_en), tbl[i].rd);
            if (tbl[i].ov != 0) chk($sformatf("tbl%0d_data", i), int'(rd_data), int'(tbl[i].data));
            step(tbl[i].iv, tbl[i].d, tbl[i].ordy);
        end

        // Streaming: 20 words back to back, level must stay at or below two.
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 8'(i), 1'b1);
            chk("stream_level_le2", (int'(level) <= 2) ? 1 : 0, 1);
        end
        for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1);
        chk("stream_drained", int'(level), 0);

        // Asynchronous reset between edges while data is in flight.
        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h40 + i), 1'b0);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_level", int'(level), 0);
        chk("arst_out_valid", int'(out_valid), 0);
        chk("arst_in_ready", int'(in_ready), 1);
        chk("arst_rd_en", int'(ram_rd_en), 0);
        chk("arst_wr_addr", int'(ram_wr_addr), 0);
        #1;
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        step(1'b1, 8'h5A, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1);

        // Random traffic alternating between drain-biased and fill-biased phases.
        for (int i = 0; i < 400; i++) begin
            logic ordy;
            if ((i / 50) % 2 == 0) ordy = ($urandom_range(0, 3) != 0);
            else                   ordy = ($urandom_range(0, 3) == 0);
            step(1'($urandom_range(0, 1)), 8'($urandom), ordy);
        end
        for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1);
        chk("final_level", int'(level), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
